// File: rtl/shake_pkg.sv
// Shared SHAKE core definitions: lane geometry, rate sizes and squeeze FSM states.
package shake_pkg;

  localparam int LANE_W        = 64;
  localparam int RATE128_LANES = 21;
  localparam int RATE256_LANES = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PERM,
    STREAM,
    REQ_PERM
  } squeeze_state_t;

  // Lanes in the rate portion for the selected SHAKE variant (0 = SHAKE128).
  function automatic logic [4:0] rate_lanes(input logic mode);
    return mode ? 5'(RATE256_LANES) : 5'(RATE128_LANES);
  endfunction

endpackage

// File: rtl/countern.sv
// Up-counter with a loadable terminal value; wraps to zero after reaching it.
module countern #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_max,
  input  logic [WIDTH-1:0] max_in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             count_end
);

  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks evaluate in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max   <= '0;
      r_count <= '0;
    end else if (load_max) begin
      r_max   <= max_in;
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == r_max) ? '0 : r_count + WIDTH'(1);
    end
  end

  assign count     = r_count;
  assign count_end = (r_count == r_max);

endmodule

// File: rtl/squeeze_ctrl.sv
// SHAKE squeeze controller: buffers the rate lanes of each permutation result and
// streams them out as 64-bit words, requesting more permutations until out_len is met.
module squeeze_ctrl
  import shake_pkg::*;
#(
  parameter int WORD_W  = 64,
  parameter int LEN_W   = 32,
  parameter int STATE_W = 1600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [LEN_W-1:0]   out_len,
  input  logic               state_valid,
  input  logic [STATE_W-1:0] state_in,
  output logic               perm_req,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  squeeze_state_t     r_state;
  logic [4:0]         r_rate;
  logic [LEN_W-1:0]   r_remaining;
  logic [WORD_W-1:0]  r_buf [RATE128_LANES];
  logic [WORD_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_perm_req;
  logic               r_busy;
  logic               r_done;

  logic [4:0]         w_rate_sel;
  logic               w_start_ok;
  logic               w_capture;
  logic               w_xfer;
  logic [4:0]         w_lane_idx;
  logic [4:0]         w_next_idx;
  logic               w_lane_end;
  logic               w_unused_lanes;

  assign w_rate_sel = rate_lanes(mode);
  assign w_start_ok = (r_state == IDLE) && start && (out_len != '0);
  assign w_capture  = (r_state == WAIT_PERM) && state_valid;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_next_idx = w_lane_idx + 5'd1;

  // Capacity lanes beyond the SHAKE128 rate never leave the core through here.
  assign w_unused_lanes = ^state_in[STATE_W-1:LANE_W*RATE128_LANES];

  countern #(.WIDTH(5)) u_lane_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_capture),
    .load_max  (w_start_ok),
    .max_in    (w_rate_sel - 5'd1),
    .en        (w_xfer),
    .count     (w_lane_idx),
    .count_end (w_lane_end)
  );

  // NOTE: the rate buffer is reset explicitly so no stale lane from an aborted
  // squeeze is observable; the reset is cheap next to the 1344 data flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RATE128_LANES; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < RATE128_LANES; i++) begin
        if (5'(i) < r_rate) r_buf[i] <= state_in[LANE_W*i +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rate      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_perm_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_perm_req <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (out_len != '0) begin
              r_rate      <= w_rate_sel;
              r_remaining <= out_len;
              r_busy      <= 1'b1;
              r_state     <= WAIT_PERM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        WAIT_PERM: begin
          if (state_valid) begin
            // Lane 0 goes straight to the output register; the rest come from r_buf.
            r_out_data  <= state_in[LANE_W-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remaining == LEN_W'(1));
            r_state     <= STREAM;
          end
        end

        STREAM: begin
          if (out_ready) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_out_data  <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
            end else if (w_lane_end) begin
              r_out_data  <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_perm_req  <= 1'b1;
              r_state     <= REQ_PERM;
            end else begin
              r_out_data  <= r_buf[w_next_idx];
              r_out_last  <= (r_remaining == LEN_W'(2));
            end
          end
        end

        REQ_PERM: r_state <= WAIT_PERM;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign perm_req  = r_perm_req;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_squeeze_ctrl.sv
// Directed bench for squeeze_ctrl: table of squeeze lengths plus hand-written
// backpressure, zero-length and mid-stream reset sequences.
module tb_squeeze_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [31:0]   out_len = '0;
  logic          state_valid = 1'b0;
  logic [1599:0] state_in = '0;
  logic          perm_req;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  squeeze_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .out_len     (out_len),
    .state_valid (state_valid),
    .state_in    (state_in),
    .perm_req    (perm_req),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    int   len;
    int   perms;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1599:0] mk_state(input int base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'(base + i);
    return s;
  endfunction

  // Runs one squeeze with out_ready held high; block b carries lanes 100*b + i.
  task automatic run_vec(input vec_t v);
    int rate;
    int k;
    int perms;
    bit sv_next;
    bit exp_valid;
    bit exp_perm;
    bit exp_done;
    bit finished;
    rate = v.mode ? 17 : 21;
    k = 0; perms = 0;
    sv_next = 1'b1; exp_valid = 1'b0; exp_perm = 1'b0; exp_done = 1'b0; finished = 1'b0;
    mode = v.mode; out_len = 32'(v.len); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~v.mode; out_len = 32'd7;
    check("busy after start", 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      state_valid = 1'b0;
      if (exp_valid) begin
        check("valid one cycle after state_valid", 64'(out_valid), 64'd1);
        exp_valid = 1'b0;
      end
      if (exp_perm) begin
        check("perm_req after last rate lane", 64'(perm_req), 64'd1);
        exp_perm = 1'b0;
      end
      if (exp_done) begin
        check("done pulse", 64'(done), 64'd1);
        check("busy falls", 64'(busy), 64'd0);
        check("valid low after done", 64'(out_valid), 64'd0);
        finished = 1'b1;
      end else if (sv_next) begin
        state_in = mk_state(perms * 100);
        state_valid = 1'b1;
        sv_next = 1'b0;
        exp_valid = 1'b1;
      end else if (perm_req) begin
        perms++;
        // Junk permutation during REQ_PERM must be ignored.
        state_in = mk_state(999);
        state_valid = 1'b1;
        sv_next = 1'b1;
      end else if (out_valid) begin
        check($sformatf("word %0d data", k), out_data, 64'((k / rate) * 100 + (k % rate)));
        check($sformatf("word %0d last", k), 64'(out_last), 64'(k == v.len - 1));
        if (k == v.len - 1) exp_done = 1'b1;
        else if (k % rate == rate - 1) exp_perm = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    state_valid = 1'b0;
    if (!finished) check("squeeze timeout", 64'd0, 64'd1);
    check("perm_req count", 64'(perms), 64'(v.perms));
    check("words streamed", 64'(k), 64'(v.len));
    check("done is one cycle", 64'(done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 1'b0, len: 4,  perms: 0};
    vecs[1] = '{mode: 1'b1, len: 20, perms: 1};
    vecs[2] = '{mode: 1'b0, len: 21, perms: 0};
    vecs[3] = '{mode: 1'b0, len: 43, perms: 2};
    vecs[4] = '{mode: 1'b1, len: 1,  perms: 0};

    #3 rst = 1'b1;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", out_data, 64'd0);
    check("reset perm_req", 64'(perm_req), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Backpressure: ready 1,0,0,1 over a two-word squeeze.
    mode = 1'b0; out_len = 32'd2; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; state_in = mk_state(0); state_valid = 1'b1;
    @(negedge clk); state_valid = 1'b0;
    check("bp word0", out_data, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp word1", out_data, 64'd1);
    check("bp last", 64'(out_last), 64'd1);
    out_ready = 1'b0;
    @(negedge clk);
    check("bp hold data", out_data, 64'd1);
    check("bp hold valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp hold data 2", out_data, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp done", 64'(done), 64'd1);
    check("bp no dup", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Zero-length request.
    out_len = 32'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero done", 64'(done), 64'd1);
    check("zero busy", 64'(busy), 64'd0);
    check("zero valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("zero done one cycle", 64'(done), 64'd0);
    check("zero valid stays low", 64'(out_valid), 64'd0);

    // Reset in the middle of STREAM after five of ten words.
    mode = 1'b0; out_len = 32'd10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; state_in = mk_state(0); state_valid = 1'b1;
    @(negedge clk); state_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset word5", out_data, 64'd5);
    #2 rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort out_data", out_data, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_last", 64'(out_last), 64'd0);
    check("abort perm_req", 64'(perm_req), 64'd0);
    @(negedge clk); rst = 1'b0;
    check("abort no done", 64'(done), 64'd0);
    mode = 1'b1; out_len = 32'd2; start = 1'b1;
    @(negedge clk); start = 1'b0; state_in = mk_state(50); state_valid = 1'b1;
    @(negedge clk); state_valid = 1'b0;
    check("post-reset word0", out_data, 64'd50);
    check("post-reset last0", 64'(out_last), 64'd0);
    @(negedge clk);
    check("post-reset word1", out_data, 64'd51);
    check("post-reset last1", 64'(out_last), 64'd1);
    @(negedge clk);
    check("post-reset done", 64'(done), 64'd1);
    check("post-reset no perm", 64'(perm_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/squeeze_ctrl.md
Name: squeeze_ctrl

Overview:
- Output-side controller of the SHAKE core; it is the squeeze counterpart of the absorb-side word counter.
- Captures the rate portion of the Keccak state after each permutation and streams it out as 64-bit words over a valid/ready handshake.
- Tracks the remaining requested output length and requests further permutations when the rate block is exhausted.
- Sits between the permutation core and the downstream output FIFO/consumer.

Parameters:
- WORD_W, 64, output word width; fixed to the Keccak lane width.
- LEN_W, 32, width of the requested output length, counted in words.
- STATE_W, 1600, Keccak state width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a squeeze; honoured only in IDLE
- mode  in  1  0 = SHAKE128 (rate 21 lanes), 1 = SHAKE256 (rate 17 lanes); sampled at start
- out_len  in  LEN_W  number of output words requested; sampled at start
- state_valid  in  1  permutation result on state_in is valid this cycle
- state_in  in  STATE_W  Keccak state; lane i = state_in[64*i +: 64]
- perm_req  out  1  one-cycle pulse requesting another permutation
- out_data  out  WORD_W  current output word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the word
- out_last  out  1  high with the final requested word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the squeeze completes

Behaviour:
- Reset values: FSM in IDLE. perm_req, out_valid, out_last, busy, done all 0. out_data 0. Internal length, lane index and rate buffer cleared.
- FSM states and transitions:
  - IDLE:
    - On start with out_len != 0: latch rate (21 or 17) and out_len, then go to WAIT_PERM.
    - On start with out_len == 0: stay in IDLE and pulse done on the following cycle.
    - start is ignored in every other state.
  - WAIT_PERM:
    - On state_valid: capture lanes 0..rate-1 into the rate buffer, clear the lane index, go to STREAM.
    - No output is presented in this state.
  - STREAM:
    - out_valid = 1; out_data = buffer[lane index], registered from the buffer so no combinational path from state_in.
    - out_last = 1 when remaining == 1.
    - A transfer is out_valid && out_ready; each transfer decrements remaining and increments the lane index.
    - Transfer with remaining == 1: go to IDLE and pulse done in the next cycle.
    - Otherwise, transfer at lane index == rate-1: go to REQ_PERM.
    - out_data and out_valid hold stable while out_ready is low.
  - REQ_PERM: perm_req = 1 for exactly one cycle, then go to WAIT_PERM.
- Throughput and latency:
  - One word per cycle when out_ready is held high.
  - First out_valid appears 1 cycle after state_valid.
  - perm_req asserts 1 cycle after the transfer of the last rate lane.
- Boundary conditions:
  - Length ending exactly on a rate boundary (e.g. 21 words in SHAKE128): go to IDLE with no perm_req.
  - Lane index wraps to 0 on each new capture.
  - Remaining count never underflows.
  - state_valid outside WAIT_PERM is ignored.
  - Reset mid-operation aborts immediately: no done, no perm_req, outputs return to their reset values.
  - mode and out_len changes after start have no effect until the next start.

Decomposition:
- Shared package shake_pkg holds:
  - localparams RATE128_LANES = 21 and RATE256_LANES = 17;
  - LANE_W = 64;
  - the squeeze_state_t enum {IDLE, WAIT_PERM, STREAM, REQ_PERM}.
- The lane index uses the existing countern (WIDTH 5):
  - load_max with rate-1 at start;
  - en on each transfer;
  - count_end marks the last rate lane.
- The remaining-length down-counter and the rate buffer (21 x 64) are local to this block.

Test Plan:
1. SHAKE128, out_len=4, out_ready=1, state lane i = i → data 0,1,2,3 on consecutive cycles; out_last with 3; done 1 cycle later; perm_req never asserted.
2. SHAKE256, out_len=20 → 17 words, then one perm_req pulse; after the second state_valid (lanes = 100+i), words 100,101,102; out_last on 102.
3. SHAKE128, out_len=21 → all 21 lanes, out_last on lane 20, no perm_req, done pulse, busy falls.
4. Backpressure: out_ready toggles 1,0,0,1 → out_data holds during the low cycles; no word is dropped or duplicated; order is 0,1.
5. out_len=0 start → done pulse next cycle, busy stays 0, out_valid never asserts.
6. Reset asserted mid-STREAM after 5 of 10 words → all outputs 0 asynchronously; a subsequent start with out_len=2 streams lanes 0,1 of the new state.
